// File: rtl/io_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : io_bus_pkg
// Purpose  : State encoding, default widths and I/O register map for the
//            two-master I/O bus arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package io_bus_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_DONE   = 2'd2;

   localparam int DEF_ADDR_W = 16;
   localparam int DEF_DATA_W = 16;

   localparam logic [15:0] REG_SW        = 16'h0000;
   localparam logic [15:0] REG_BTN       = 16'h0002;
   localparam logic [15:0] REG_LED       = 16'h0010;
   localparam logic [15:0] REG_DISP0     = 16'h0020;
   localparam logic [15:0] REG_DISP1     = 16'h0021;
   localparam logic [15:0] REG_DISP2     = 16'h0022;
   localparam logic [15:0] REG_DISP3     = 16'h0023;
   localparam logic [15:0] REG_DISP_CTRL = 16'h0024;

endpackage
`default_nettype wire

// File: rtl/io_bus_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Purpose  : Combinational two-requester grant selection, round-robin or
//            fixed priority (requester 0 wins ties).
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb2 #(
   parameter int FIXED_PRIO = 0
) (
   input  logic req0,
   input  logic req1,
   input  logic last_grant,
   output logic valid,
   output logic grant
);

   always_comb begin
      valid = req0 | req1;
      grant = 1'b0;
      if (req0 && req1) begin
         grant = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant;
      end else if (req1) begin
         grant = 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/io_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : io_bus_arbiter
// Purpose  : Shares the I/O register bus between two masters, one complete
//            req/ack transaction at a time, with fully registered outputs.
// Revision : 1.0 - initial release
// ============================================================================
module io_bus_arbiter
   import io_bus_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int FIXED_PRIO = 0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              m0_req,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   input  logic              m0_we,
   output logic              m0_ack,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_req,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   input  logic              m1_we,
   output logic              m1_ack,
   output logic [DATA_W-1:0] m1_rdata,
   output logic [ADDR_W-1:0] io_addr,
   output logic [DATA_W-1:0] io_wdata,
   output logic              io_we,
   input  logic [DATA_W-1:0] io_rdata,
   output logic              busy
);

   logic [1:0] state;
   logic [1:0] next_state;
   logic       grant;
   logic       last_grant;
   logic       arb_valid;
   logic       arb_grant;
   logic       load;
   logic       capture;

   rr_arb2 #(
      .FIXED_PRIO (FIXED_PRIO)
   ) u_arb (
      .req0       (m0_req),
      .req1       (m1_req),
      .last_grant (last_grant),
      .valid      (arb_valid),
      .grant      (arb_grant)
   );

   // last_grant resets to 1 so master 0 wins the first tie
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ST_IDLE;
         grant      <= 1'b0;
         last_grant <= 1'b1;
      end else begin
         state <= next_state;
         if (load) begin
            grant      <= arb_grant;
            last_grant <= arb_grant;
         end
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE:   if (arb_valid) next_state = ST_ACCESS;
         ST_ACCESS: next_state = ST_DONE;
         ST_DONE:   next_state = ST_IDLE;
         default:   next_state = ST_IDLE;
      endcase
   end

   always_comb begin
      load    = (state == ST_IDLE) && arb_valid;
      capture = (state == ST_ACCESS);
   end

   // io_we is high only during ACCESS; address/data hold otherwise
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         io_addr  <= '0;
         io_wdata <= '0;
         io_we    <= 1'b0;
         m0_ack   <= 1'b0;
         m1_ack   <= 1'b0;
         m0_rdata <= '0;
         m1_rdata <= '0;
         busy     <= 1'b0;
      end else begin
         busy   <= (next_state != ST_IDLE);
         io_we  <= load ? (arb_grant ? m1_we : m0_we) : 1'b0;
         m0_ack <= capture && !grant;
         m1_ack <= capture && grant;
         if (load) begin
            io_addr  <= arb_grant ? m1_addr  : m0_addr;
            io_wdata <= arb_grant ? m1_wdata : m0_wdata;
         end
         if (capture && !grant) m0_rdata <= io_rdata;
         if (capture && grant)  m1_rdata <= io_rdata;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_io_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_io_bus_arbiter
// Purpose  : Directed scoreboard bench; one round-robin and one fixed-priority
//            arbiter share the same master stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_io_bus_arbiter;

   typedef struct {
      int          master;
      logic [15:0] rdata;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        m0_req, m0_we, m1_req, m1_we;
   logic [15:0] m0_addr, m0_wdata, m1_addr, m1_wdata, io_rdata;

   logic        rr_m0_ack, rr_m1_ack, rr_io_we, rr_busy;
   logic [15:0] rr_m0_rdata, rr_m1_rdata, rr_io_addr, rr_io_wdata;
   logic        fp_m0_ack, fp_m1_ack, fp_io_we, fp_busy;
   logic [15:0] fp_m0_rdata, fp_m1_rdata, fp_io_addr, fp_io_wdata;

   int   compared   = 0;
   int   mismatched = 0;
   int   cyc        = 0;
   exp_t sb_q[$];

   always #5 clk = ~clk;

   io_bus_arbiter #(.ADDR_W(16), .DATA_W(16), .FIXED_PRIO(0)) dut_rr (
      .clk(clk), .reset_n(reset_n),
      .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_we(m0_we),
      .m0_ack(rr_m0_ack), .m0_rdata(rr_m0_rdata),
      .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_we(m1_we),
      .m1_ack(rr_m1_ack), .m1_rdata(rr_m1_rdata),
      .io_addr(rr_io_addr), .io_wdata(rr_io_wdata), .io_we(rr_io_we),
      .io_rdata(io_rdata), .busy(rr_busy)
   );

   io_bus_arbiter #(.ADDR_W(16), .DATA_W(16), .FIXED_PRIO(1)) dut_fp (
      .clk(clk), .reset_n(reset_n),
      .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_we(m0_we),
      .m0_ack(fp_m0_ack), .m0_rdata(fp_m0_rdata),
      .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_we(m1_we),
      .m1_ack(fp_m1_ack), .m1_rdata(fp_m1_rdata),
      .io_addr(fp_io_addr), .io_wdata(fp_io_wdata), .io_we(fp_io_we),
      .io_rdata(io_rdata), .busy(fp_busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic push(input int master, input logic [15:0] rdata, input int c);
      exp_t e;
      e.master = master;
      e.rdata  = rdata;
      e.cyc    = c;
      sb_q.push_back(e);
   endtask

   task automatic check_ack(input bit fp, input logic a0, input logic a1);
      exp_t        e;
      logic [15:0] rd;
      if (sb_q.size() == 0) begin
         chk("sb_underflow", 32'(sb_q.size()), 32'd1);
      end else begin
         e  = sb_q.pop_front();
         rd = (e.master == 1) ? (fp ? fp_m1_rdata : rr_m1_rdata)
                              : (fp ? fp_m0_rdata : rr_m0_rdata);
         chk(fp ? "fp_ack_master" : "rr_ack_master", {31'd0, a1}, 32'(e.master));
         chk(fp ? "fp_ack_both" : "rr_ack_both", {31'd0, a0 & a1}, 32'd0);
         chk(fp ? "fp_ack_cycle" : "rr_ack_cycle", 32'(cyc), 32'(e.cyc));
         chk(fp ? "fp_rdata" : "rr_rdata", {16'd0, rd}, {16'd0, e.rdata});
      end
   endtask

   task automatic wait_ack(input bit fp, input int budget);
      int   n    = 0;
      bit   seen = 1'b0;
      logic a0, a1;
      while (!seen && n < budget) begin
         step();
         n++;
         a0 = fp ? fp_m0_ack : rr_m0_ack;
         a1 = fp ? fp_m1_ack : rr_m1_ack;
         if (a0 || a1) begin
            seen = 1'b1;
            check_ack(fp, a0, a1);
         end
      end
      chk(fp ? "fp_ack_timeout" : "rr_ack_timeout", {31'd0, seen}, 32'd1);
   endtask

   task automatic pulse_reset();
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "simulation timeout");
   end

   initial begin
      reset_n  = 1'b0;
      m0_req   = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
      m1_req   = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
      io_rdata = '0;
      step();
      step();

      // reset state
      chk("rst_io_we",    {31'd0, rr_io_we}, 32'd0);
      chk("rst_io_addr",  {16'd0, rr_io_addr}, 32'd0);
      chk("rst_io_wdata", {16'd0, rr_io_wdata}, 32'd0);
      chk("rst_busy",     {31'd0, rr_busy}, 32'd0);
      chk("rst_acks",     {30'd0, rr_m0_ack, rr_m1_ack}, 32'd0);
      chk("rst_rdata",    {rr_m0_rdata, rr_m1_rdata}, 32'd0);
      chk("rst_fp_out",   {fp_io_addr, 13'd0, fp_io_we, fp_busy, fp_m0_ack}, 32'd0);
      reset_n = 1'b1;
      step();

      // single write from m0 to the LED register
      m0_req = 1'b1; m0_addr = 16'h0010; m0_wdata = 16'hA5A5; m0_we = 1'b1;
      io_rdata = 16'h0F0F;
      cyc = 0;
      push(0, 16'h0F0F, 2);
      step();
      chk("wr_io_we_c1",   {31'd0, rr_io_we}, 32'd1);
      chk("wr_io_addr_c1", {16'd0, rr_io_addr}, 32'h0010);
      chk("wr_io_wdata",   {16'd0, rr_io_wdata}, 32'hA5A5);
      chk("wr_busy_c1",    {31'd0, rr_busy}, 32'd1);
      chk("wr_no_early_ack", {30'd0, rr_m0_ack, rr_m1_ack}, 32'd0);
      wait_ack(1'b0, 3);
      chk("wr_io_we_c2", {31'd0, rr_io_we}, 32'd0);
      chk("wr_fp_ack",   {30'd0, fp_m0_ack, fp_m1_ack}, 32'd2);
      m0_req = 1'b0;
      step();
      chk("wr_ack_pulse", {30'd0, rr_m0_ack, rr_m1_ack}, 32'd0);
      chk("wr_idle_busy", {31'd0, rr_busy}, 32'd0);
      chk("wr_addr_hold", {16'd0, rr_io_addr}, 32'h0010);

      // single read from m1 of the switch register
      m1_req = 1'b1; m1_addr = 16'h0000; m1_we = 1'b0; m1_wdata = 16'h7777;
      io_rdata = 16'h1234;
      cyc = 0;
      push(1, 16'h1234, 2);
      step();
      chk("rd_io_we_c1",   {31'd0, rr_io_we}, 32'd0);
      chk("rd_io_addr_c1", {16'd0, rr_io_addr}, 32'h0000);
      wait_ack(1'b0, 3);
      chk("rd_m0_rdata_kept", {16'd0, rr_m0_rdata}, 32'h0F0F);
      m1_req = 1'b0;
      step();

      // reset in the middle of an m0 write
      m0_req = 1'b1; m0_addr = 16'h0020; m0_wdata = 16'h00FF; m0_we = 1'b1;
      step();
      chk("mid_io_we_pre", {31'd0, rr_io_we}, 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("mid_io_we_async", {30'd0, rr_io_we, fp_io_we}, 32'd0);
      chk("mid_busy_async",  {30'd0, rr_busy, fp_busy}, 32'd0);
      m0_req = 1'b0;
      step();
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("mid_no_ack", {28'd0, rr_m0_ack, rr_m1_ack, fp_m0_ack, fp_m1_ack}, 32'd0);
      end
      chk("mid_io_addr", {16'd0, rr_io_addr}, 32'd0);
      chk("mid_rdata",   {rr_m0_rdata, rr_m1_rdata}, 32'd0);

      // round-robin contention: four transactions alternate 0,1,0,1
      m0_req = 1'b1; m0_addr = 16'h0021; m0_wdata = 16'h1111; m0_we = 1'b1;
      m1_req = 1'b1; m1_addr = 16'h0002; m1_wdata = 16'h2222; m1_we = 1'b0;
      io_rdata = 16'hBEEF;
      cyc = 0;
      push(0, 16'hBEEF, 2);
      push(1, 16'hBEEF, 5);
      push(0, 16'hBEEF, 8);
      push(1, 16'hBEEF, 11);
      wait_ack(1'b0, 4);
      step();
      step();
      chk("rr_m1_io_addr", {16'd0, rr_io_addr}, 32'h0002);
      chk("rr_m1_io_we",   {31'd0, rr_io_we}, 32'd0);
      wait_ack(1'b0, 4);
      wait_ack(1'b0, 4);
      wait_ack(1'b0, 4);
      m0_req = 1'b0;
      m1_req = 1'b0;
      pulse_reset();

      // fixed priority: m0 served every time until it drops req
      m0_req = 1'b1;
      m1_req = 1'b1;
      io_rdata = 16'hC0DE;
      cyc = 0;
      push(0, 16'hC0DE, 2);
      push(0, 16'hC0DE, 5);
      push(0, 16'hC0DE, 8);
      wait_ack(1'b1, 4);
      wait_ack(1'b1, 4);
      wait_ack(1'b1, 4);
      m0_req = 1'b0;
      push(1, 16'hC0DE, 11);
      wait_ack(1'b1, 3);
      m1_req = 1'b0;
      step();

      chk("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/io_bus_arbiter.md
Name: io_bus_arbiter

Overview:
- Two-master arbiter that shares the single 16-bit register bus of the on-board I/O block (switches, buttons, LEDs, 7-segment displays).
- Master 0 is the CPU. Master 1 is an auxiliary sequencer, for example a display-update or test engine.
- Grants one complete transaction at a time with a req/ack handshake, round-robin or fixed priority.
- Drives registered addr/data/we to the I/O block and returns its read data to the granted master.

Parameters:
- ADDR_W, 16, address width of all address ports.
- DATA_W, 16, data width of all data ports.
- FIXED_PRIO, 0, 0 = round-robin between masters; 1 = master 0 always wins ties.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- m0_req  input  1  master 0 transaction request; held high until m0_ack.
- m0_addr  input  ADDR_W  master 0 address; stable while m0_req is high.
- m0_wdata  input  DATA_W  master 0 write data.
- m0_we  input  1  master 0 write (1) / read (0).
- m0_ack  output  1  one-cycle pulse; transaction complete.
- m0_rdata  output  DATA_W  read data; valid when m0_ack is high and held until the next m0_ack.
- m1_req, m1_addr, m1_wdata, m1_we, m1_ack, m1_rdata  same as the m0_* ports, for master 1.
- io_addr  output  ADDR_W  address to the I/O block.
- io_wdata  output  DATA_W  write data to the I/O block.
- io_we  output  1  write enable to the I/O block.
- io_rdata  input  DATA_W  combinational read data from the I/O block.
- busy  output  1  high while the state is not IDLE.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; io_we=0; io_addr=0; io_wdata=0.
  - m0_ack=m1_ack=0; m0_rdata=m1_rdata=0; busy=0.
  - last_grant=1, so master 0 wins the first tie.
  - Reset mid-transaction abandons it: io_we drops immediately, and no ack is issued after reset releases.
- States: IDLE -> ACCESS -> DONE -> IDLE. Every output is registered.
- IDLE:
  - No req: stay in IDLE.
  - Any req: select the winner, latch the winner's addr/wdata/we into io_addr/io_wdata/io_we and record grant. Next state ACCESS.
- Selection:
  - Only one req high: that master wins.
  - Both high, FIXED_PRIO=1: master 0 wins.
  - Both high, FIXED_PRIO=0: the master that is not last_grant wins. last_grant updates on entry to ACCESS.
- ACCESS (exactly 1 cycle):
  - io_addr/io_wdata/io_we are stable all cycle; the I/O block performs its write on the closing edge.
  - io_rdata is captured into the granted master's rdata register on the closing edge, for both reads and writes.
  - Next state DONE; io_we clears on entry to DONE.
- DONE (1 cycle): granted master's ack=1 and rdata is valid. Next state IDLE.
- Latency and throughput:
  - req seen in IDLE at cycle N gives ACCESS at N+1 and ack at N+2.
  - Minimum spacing is 3 cycles per transaction; the bus is re-arbitrated after every transaction.
- Master obligations:
  - The master holds req/addr/wdata/we stable until it sees ack.
  - It may keep req high after ack to issue the next transaction; that request competes in the next IDLE.
  - Dropping req before ack is a protocol violation; the arbiter completes the latched transaction anyway.
- Ack and rdata isolation: the ungranted master's ack stays 0 and its rdata is unchanged.
- io_addr/io_wdata hold their last value in IDLE and DONE; only io_we gates side effects.
- Starvation: under round-robin with both reqs continuously high, grants strictly alternate 0,1,0,1...

Decomposition:
- Shared package io_bus_pkg holds:
  - state encoding: IDLE=2'd0, ACCESS=2'd1, DONE=2'd2;
  - default ADDR_W/DATA_W;
  - I/O register offsets: SW=0x00, BTN=0x02, LED=0x10, DISP0..3=0x20-0x23, DISP_CTRL=0x24.
- One natural sub-module: rr_arb2. It is combinational grant selection from (req0, req1, last_grant, FIXED_PRIO) and is reused by the FSM.

Test Plan:
- Reset mid-transaction: m0 write in ACCESS, pulse reset_n low -> io_we=0 immediately; no m0_ack after release; state IDLE, all outputs 0.
- Single write: m0_req=1, m0_addr=0x0010, m0_wdata=0xA5A5, m0_we=1 at cycle 0 -> io_we=1 with io_addr=0x0010 in cycle 1 only; m0_ack=1 in cycle 2; m1_ack stays 0.
- Single read: m1_req=1, m1_addr=0x0000, m1_we=0, io_rdata=0x1234 -> m1_ack=1 and m1_rdata=0x1234 in cycle 2; m0_rdata unchanged.
- Contention with FIXED_PRIO=0, both reqs high continuously for 4 transactions -> grant order 0,1,0,1; acks 3 cycles apart at cycles 2,5,8,11.
- Contention with FIXED_PRIO=1, both reqs high -> m0 served every transaction and m1 never acked; when m0_req drops, m1 is acked within 3 cycles.
